// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus bundle: the imem read port plus the decode-side valid/ready handshake.
// master = fetch stage, slave = imem/decode side.
interface instr_fetch_stage_if #(
  parameter int ADDR_W = 10
);
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [31:0]       if_pc;
  logic              if_fault;
  logic              id_ready;

  modport master (
    output imem_en, imem_addr, if_valid, if_instr, if_pc, if_fault,
    input  imem_rdata, id_ready
  );

  modport slave (
    input  imem_en, imem_addr, if_valid, if_instr, if_pc, if_fault,
    output imem_rdata, id_ready
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// MIPS instruction fetch: issues imem reads, queues {instr, pc} in a 2-entry FIFO for decode,
// flushes on redirect. Optional misaligned-redirect fault guarded by IF_ALIGN_CHECK_EN.
module instr_fetch_stage #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  instr_fetch_stage_if.master   bus
);

  logic [31:0] pc;
  logic        started;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic [31:0] q_instr [2];
  logic [31:0] q_pc    [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        fault;
  logic [1:0]  occupancy;
  logic        pop;
  logic        push;
  logic        issue;
  logic        flush;

  // In-flight reads count against queue space, so a returning word always has a slot.
  assign occupancy = count + {1'b0, inflight};
  assign pop       = (count != 2'd0) && bus.id_ready;
  assign flush     = redirect || fault;
  assign issue     = started && !flush &&
                     ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
  assign push      = inflight && !flush;

  assign bus.imem_en   = issue;
  assign bus.imem_addr = issue ? pc[ADDR_W+1:2] : '0;
  assign bus.if_valid  = (count != 2'd0);
  assign bus.if_instr  = bus.if_valid ? q_instr[rd_ptr] : 32'h0;
  assign bus.if_pc     = bus.if_valid ? q_pc[rd_ptr]    : 32'h0;
  assign bus.if_fault  = fault;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      started     <= 1'b0;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_instr[i] <= 32'h0;
        q_pc[i]    <= 32'h0;
      end
    end else begin
      started  <= 1'b1;
      inflight <= issue;
      if (issue) inflight_pc <= pc;

      if (redirect)   pc <= {redirect_pc[31:2], 2'b00};
      else if (issue) pc <= pc + 32'd4;

      // A response returning in a flush cycle is dropped here, which is what kills it.
      if (flush) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          q_instr[wr_ptr] <= bus.imem_rdata;
          q_pc[wr_ptr]    <= inflight_pc;
          wr_ptr          <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         fault <= 1'b0;
    else if (redirect && (redirect_pc[1:0] != 2'b00)) fault <= 1'b1;
  end
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^redirect_pc[1:0];
  assign fault          = 1'b0;
`endif

endmodule
